// File: rtl/ad9833_pkg.sv
// Shared constants and types for the AD9833 configuration sequencer:
// control-word bit patterns, register prefixes, waveform mode codes and FSM states.
package ad9833_pkg;

  localparam logic [15:0] CTRL_B28   = 16'h2000;
  localparam logic [15:0] CTRL_RESET = 16'h0100;
  localparam logic [15:0] REG_FREQ0  = 16'h4000;
  localparam logic [15:0] REG_PHASE0 = 16'hC000;

  localparam logic [15:0] MODE_SINE        = 16'h0000;
  localparam logic [15:0] MODE_TRIANGLE    = 16'h0002;
  localparam logic [15:0] MODE_SQUARE      = 16'h0028;
  localparam logic [15:0] MODE_SQUARE_DIV2 = 16'h0020;

  localparam logic [2:0] LAST_WORD_IDX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_TAIL,
    ST_GAP,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    WAVE_SINE        = 2'b00,
    WAVE_TRIANGLE    = 2'b01,
    WAVE_SQUARE      = 2'b10,
    WAVE_SQUARE_DIV2 = 2'b11
  } wave_e;

  // Control-register mode bits (OPBITEN/DIV2/MODE) for the selected waveform.
  function automatic logic [15:0] mode_bits(input logic [1:0] wave);
    logic [15:0] bits;
    case (wave)
      WAVE_SINE:        bits = MODE_SINE;
      WAVE_TRIANGLE:    bits = MODE_TRIANGLE;
      WAVE_SQUARE:      bits = MODE_SQUARE;
      default:          bits = MODE_SQUARE_DIV2;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/ad9833_word_gen.sv
// Maps a word index and the latched configuration to the 16-bit AD9833 word.
module ad9833_word_gen
  import ad9833_pkg::*;
(
  input  logic [2:0]  word_idx,
  input  logic [27:0] freq_word,
  input  logic [11:0] phase_word,
  input  logic [1:0]  wave_sel,
  output logic [15:0] word
);

  // Word order: reset with B28, FREQ0 LSBs, FREQ0 MSBs, PHASE0, then release reset with the mode.
  always_comb begin
    word = 16'h0000;
    case (word_idx)
      3'd0:    word = CTRL_B28 | CTRL_RESET;
      3'd1:    word = REG_FREQ0 | {2'b00, freq_word[13:0]};
      3'd2:    word = REG_FREQ0 | {2'b00, freq_word[27:14]};
      3'd3:    word = REG_PHASE0 | {4'h0, phase_word};
      3'd4:    word = CTRL_B28 | mode_bits(wave_sel);
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ad9833_cfg_seq.sv
// Sequences the five configuration words into an AD9833 serializer, with
// per-frame handshake, tail hold, inter-frame gap and a finish timeout.
module ad9833_cfg_seq
  import ad9833_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int FIN_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [27:0] freq_word,
  input  logic [11:0] phase_word,
  input  logic [1:0]  wave_sel,
  output logic [15:0] ad9833_data,
  output logic        ad9833_wr_en,
  input  logic        ad9833_wr_finish,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_MAX = (GAP_CYCLES > FIN_TIMEOUT) ? GAP_CYCLES : FIN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [27:0]      freq_q, freq_d;
  logic [11:0]      phase_q, phase_d;
  logic [1:0]       wave_q, wave_d;
  logic [15:0]      data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      next_word;

  // The word generator sees next-state values so the word is already on the bus during LOAD.
  ad9833_word_gen u_word_gen (
    .word_idx   (idx_d),
    .freq_word  (freq_d),
    .phase_word (phase_d),
    .wave_sel   (wave_d),
    .word       (next_word)
  );

  // Next-state, index, counter, latch and pulse logic of the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    wave_d  = wave_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          freq_d  = freq_word;
          phase_d = phase_word;
          wave_d  = wave_sel;
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ad9833_wr_finish) begin
          cnt_d   = '0;
          state_d = ST_TAIL;
        end else if (cnt_q == SEND_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_WORD_IDX) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    wr_en_d = (state_d == ST_SEND) || (state_d == ST_TAIL);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_SEND) ||
              (state_d == ST_TAIL) || (state_d == ST_GAP);
    data_d  = (state_d == ST_LOAD) ? next_word : data_q;
  end

  // Single state register for the FSM, counters, latched inputs and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      wave_q  <= '0;
      data_q  <= 16'h0000;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      wave_q  <= wave_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ad9833_data  = data_q;
  assign ad9833_wr_en = wr_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
